// File: rtl/ser_deframer.sv
// Serial link deframer: registers the LSB-first bit stream and its word strobe,
// acquires/tracks word alignment, and emits assembled 8-bit words with lock and error status.
module ser_deframer #(
   parameter int LOCK_COUNT = 4,
   parameter int LOSS_COUNT = 2
) (
   input  logic       fast_clk,
   input  logic       rst_n,
   input  logic       data_in,
   input  logic       sync_in,
   output logic [7:0] word,
   output logic [1:0] r0_i,
   output logic [1:0] r0_q,
   output logic [1:0] r1_i,
   output logic [1:0] r1_q,
   output logic       word_valid,
   output logic       locked,
   output logic [7:0] err_cnt
);

   typedef enum logic [1:0] {
      S_HUNT   = 2'd0,
      S_VERIFY = 2'd1,
      S_LOCKED = 2'd2
   } state_t;

   localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
   localparam logic [3:0] LOSS_N = 4'(LOSS_COUNT);

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   state_t     state, state_nxt;
   logic       data_r, sync_r;
   logic [2:0] bit_cnt, bit_cnt_nxt;
   logic [3:0] good, good_nxt;
   logic [3:0] bad, bad_nxt;
   logic [7:0] shreg, shreg_nxt;
   logic [7:0] word_nxt, err_nxt;
   logic       valid_nxt;
   logic       slot0, good_bnd, missing, sync_err;

   assign slot0    = (bit_cnt == 3'd0);
   assign good_bnd = sync_r & slot0;
   assign missing  = ~sync_r & slot0;
   // A strobe off the expected slot or an absent one in the slot are both errors.
   assign sync_err = sync_r ^ slot0;

   // Input sampling stage
   always_ff @(posedge fast_clk or negedge rst_n) begin
      if (!rst_n) begin
         data_r <= 1'b0;
         sync_r <= 1'b0;
      end else begin
         data_r <= data_in;
         sync_r <= sync_in;
      end
   end

   // Alignment and assembly stage
   always_comb begin
      state_nxt   = state;
      bit_cnt_nxt = bit_cnt + 3'd1;
      good_nxt    = good;
      bad_nxt     = bad;
      shreg_nxt   = shreg;
      word_nxt    = word;
      err_nxt     = err_cnt;
      valid_nxt   = 1'b0;

      case (state)
         S_HUNT: begin
            bit_cnt_nxt = 3'd0;
            if (sync_r) begin
               shreg_nxt[0] = data_r;
               bit_cnt_nxt  = 3'd1;
               good_nxt     = 4'd1;
               state_nxt    = S_VERIFY;
            end
         end

         S_VERIFY: begin
            shreg_nxt[bit_cnt] = data_r;
            if (good_bnd) begin
               good_nxt = good + 4'd1;
               if (good + 4'd1 == LOCK_N) begin
                  state_nxt = S_LOCKED;
                  bad_nxt   = 4'd0;
               end
            end else if (missing) begin
               state_nxt   = S_HUNT;
               bit_cnt_nxt = 3'd0;
            end else if (sync_r) begin
               shreg_nxt[0] = data_r;
               bit_cnt_nxt  = 3'd1;
               good_nxt     = 4'd1;
            end
         end

         S_LOCKED: begin
            shreg_nxt[bit_cnt] = data_r;
            if (bit_cnt == 3'd7) begin
               word_nxt  = shreg_nxt;
               valid_nxt = 1'b1;
            end
            if (sync_err) begin
               bad_nxt = bad + 4'd1;
               err_nxt = sat_inc(err_cnt);
               if (bad + 4'd1 >= LOSS_N) begin
                  state_nxt   = S_HUNT;
                  bit_cnt_nxt = 3'd0;
               end
            end else if (good_bnd) begin
               bad_nxt = 4'd0;
            end
         end

         default: begin
            state_nxt   = S_HUNT;
            bit_cnt_nxt = 3'd0;
         end
      endcase
   end

   // Output register stage
   always_ff @(posedge fast_clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_HUNT;
         bit_cnt    <= 3'd0;
         good       <= 4'd0;
         bad        <= 4'd0;
         shreg      <= 8'd0;
         word       <= 8'd0;
         err_cnt    <= 8'd0;
         word_valid <= 1'b0;
      end else begin
         state      <= state_nxt;
         bit_cnt    <= bit_cnt_nxt;
         good       <= good_nxt;
         bad        <= bad_nxt;
         shreg      <= shreg_nxt;
         word       <= word_nxt;
         err_cnt    <= err_nxt;
         word_valid <= valid_nxt;
      end
   end

   assign locked = (state == S_LOCKED);
   assign r0_i   = word[7:6];
   assign r0_q   = word[5:4];
   assign r1_i   = word[3:2];
   assign r1_q   = word[1:0];

endmodule
